fp_to_posit_seq: RTL

Multi-cycle IEEE 754 to posit converter with valid/ready handshakes on both sides; the inverse companion of the posit-to-FP convertor in the posit arithmetic unit. It converts FP load and move operands into posits for the posit datapath. The regime is built one bit per cycle, so the latency depends on the operand. The serial build keeps area small at the cost of throughput (one conversion in flight).

---
 rtl/posit_pkg.sv | 35 +++
 rtl/fp_lzc.sv | 20 ++
 rtl/fp_to_posit_seq.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/posit_pkg.sv
// Shared state encoding, posit special constants and the round-to-nearest-even
// helper for the IEEE 754 to posit converter.
package posit_pkg;

  localparam int PN  = 32;
  localparam int PES = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    SHIFT  = 3'd2,
    ROUND  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [PN-1:0] NAR    = {1'b1, {(PN-1){1'b0}}};
  localparam logic [PN-1:0] MAXPOS = {1'b0, {(PN-1){1'b1}}};
  localparam logic [PN-1:0] MINPOS = {{(PN-1){1'b0}}, 1'b1};

  // Rounds the unsigned magnitude and clamps it into [minpos, maxpos].
  function automatic logic [PN-1:0] round_mag(input logic [PN-2:0] mag,
                                              input logic          g,
                                              input logic          st);
    logic [PN-1:0] sum;
    sum = {1'b0, mag} + {{(PN-1){1'b0}}, g & (st | mag[0])};
    if (sum[PN-1]) begin
      return MAXPOS;
    end
    if (sum == '0) begin
      return MINPOS;
    end
    return sum;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter over the FP fraction field; an all-zero
// input reports M.
module fp_lzc #(
  parameter int M = 23,
  parameter int W = $clog2(M + 1)
) (
  input  logic [M-1:0] i_val,
  output logic [W-1:0] o_lz
);

  always_comb begin
    o_lz = W'(M);
    for (int b = 0; b < M; b++) begin
      if (i_val[b]) begin
        o_lz = W'(M - 1 - b);
      end
    end
  end

endmodule

// File: rtl/fp_to_posit_seq.sv
// Serial IEEE 754 binary32 to posit<32,2> converter: the regime is shifted in
// one bit per cycle, so only one conversion is in flight at a time.
module fp_to_posit_seq
  import posit_pkg::*;
#(
  parameter int FPWID = PN
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [FPWID-1:0] i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [FPWID-1:0] o
);

  localparam int E    = 8;
  localparam int M    = 23;
  localparam int BIAS = 127;
  localparam int ES   = PES;
  localparam int SRW  = FPWID - 1 + ES + M + 2;
  localparam int LZW  = $clog2(M + 1);
  localparam int UEW  = 10;
  localparam int SW   = 5;
  localparam logic signed [UEW-1:0] K_HI = UEW'(FPWID - 3);
  localparam logic signed [UEW-1:0] K_LO = UEW'(2 - FPWID);

  state_t            r_state;
  logic [FPWID-1:0]  r_in;
  logic [SRW-1:0]    r_sr;
  logic [SW-1:0]     r_s;
  logic              r_rbit;
  logic              r_sticky;
  logic [FPWID-1:0]  r_o;

  logic [E-1:0]          w_exp;
  logic [M-1:0]          w_frac;
  logic [M-1:0]          w_fman;
  logic [LZW-1:0]        w_lz;
  logic signed [UEW-1:0] w_ue;
  logic signed [UEW-1:0] w_k;
  logic [ES-1:0]         w_ef;
  logic                  w_rbit;
  logic [SW-1:0]         w_s;
  logic                  w_denorm;
  logic                  w_zero;
  logic                  w_infnan;
  logic                  w_big;
  logic                  w_small;
  logic [FPWID-1:0]      w_sat;
  logic [FPWID-1:0]      w_sat_o;
  logic [FPWID-2:0]      w_mag;
  logic                  w_g;
  logic                  w_st;
  logic [FPWID-1:0]      w_pos;
  logic [FPWID-1:0]      w_round_o;

  assign w_exp  = r_in[FPWID-2 -: E];
  assign w_frac = r_in[M-1:0];

  fp_lzc #(.M(M), .W(LZW)) u_lzc (
    .i_val (w_frac),
    .o_lz  (w_lz)
  );

  // Denormals are renormalised so that the hidden bit sits just above the field.
  always_comb begin
    w_denorm = (w_exp == '0);
    if (w_denorm) begin
      w_fman = w_frac << (w_lz + LZW'(1));
      w_ue   = -UEW'(BIAS) - UEW'(w_lz);
    end else begin
      w_fman = w_frac;
      w_ue   = UEW'(w_exp) - UEW'(BIAS);
    end
    w_k    = w_ue >>> ES;
    w_ef   = w_ue[ES-1:0];
    w_rbit = ~w_k[UEW-1];
    w_s    = w_rbit ? (w_k[SW-1:0] + SW'(1)) : (SW'(0) - w_k[SW-1:0]);
  end

  assign w_zero   = w_denorm && (w_frac == '0);
  assign w_infnan = &w_exp;
  assign w_big    = (w_k > K_HI);
  assign w_small  = (w_k < K_LO);
  assign w_sat    = w_big ? MAXPOS : MINPOS;
  assign w_sat_o  = r_in[FPWID-1] ? (FPWID'(0) - w_sat) : w_sat;

  assign w_mag     = r_sr[SRW-1 -: FPWID-1];
  assign w_g       = r_sr[SRW-FPWID];
  assign w_st      = (|r_sr[SRW-FPWID-1:0]) | r_sticky;
  assign w_pos     = round_mag(w_mag, w_g, w_st);
  assign w_round_o = r_in[FPWID-1] ? (FPWID'(0) - w_pos) : w_pos;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_in     <= '0;
      r_sr     <= '0;
      r_s      <= '0;
      r_rbit   <= 1'b0;
      r_sticky <= 1'b0;
      r_o      <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid_i) begin
            r_in    <= i;
            r_state <= DECODE;
          end
        end
        DECODE: begin
          if (w_zero) begin
            r_o     <= '0;
            r_state <= DONE;
          end else if (w_infnan) begin
            r_o     <= NAR;
            r_state <= DONE;
          end else if (w_big || w_small) begin
            r_o     <= w_sat_o;
            r_state <= DONE;
          end else begin
            // Regime terminator first; the regime run is shifted in above it.
            r_sr     <= {~w_rbit, w_ef, w_fman, {(SRW-M-ES-1){1'b0}}};
            r_rbit   <= w_rbit;
            r_s      <= w_s;
            r_sticky <= 1'b0;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          r_sr     <= {r_rbit, r_sr[SRW-1:1]};
          r_sticky <= r_sticky | r_sr[0];
          r_s      <= r_s - SW'(1);
          if (r_s == SW'(1)) begin
            r_state <= ROUND;
          end
        end
        ROUND: begin
          r_o     <= w_round_o;
          r_state <= DONE;
        end
        DONE: begin
          if (out_ready_i) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = rst_ni && (r_state == IDLE);
  assign out_valid_o = (r_state == DONE);
  assign o           = r_o;

endmodule
